// File: rtl/decoder_pipe_arm_if.sv
// Fetch-side and execute-side handshake bundle for decoder_pipe_arm.
// The slave modport is the decode stage; the master modport is the surrounding fetch/execute logic.
interface decoder_pipe_arm_if #(
  parameter int ADDR_W = 32,
  parameter int STAT_W = 32
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_code;
  logic [ADDR_W-1:0] in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        out_class;
  logic [3:0]        out_cond;
  logic [3:0]        out_rd;
  logic [3:0]        out_rn;
  logic [3:0]        out_rm;
  logic [3:0]        out_rs;
  logic [31:0]       out_code;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_b_target;
  logic [STAT_W-1:0] stat_insn;
  logic [STAT_W-1:0] stat_stall;

  modport slave (
    input  flush, in_valid, in_code, in_pc, out_ready,
    output in_ready, out_valid, out_class, out_cond, out_rd, out_rn, out_rm, out_rs,
           out_code, out_pc, out_b_target, stat_insn, stat_stall
  );

  modport master (
    output flush, in_valid, in_code, in_pc, out_ready,
    input  in_ready, out_valid, out_class, out_cond, out_rd, out_rn, out_rm, out_rs,
           out_code, out_pc, out_b_target, stat_insn, stat_stall
  );
endinterface

// File: rtl/decoder_pipe_arm.sv
// Registered ARM decode stage: priority-encodes the instruction class, precomputes the branch
// target and buffers results in a DEPTH-entry queue. Optional counters under DECODER_STAT_EN.
module decoder_pipe_arm #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2,
  parameter int STAT_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  decoder_pipe_arm_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  function automatic logic [4:0] decode_class(input logic [31:0] c);
    logic bx, mrs, msr, msr_flag, mul, mull, swp, ldrh, ldrsb, ldrsh, hw_ok;
    logic [4:0] cls;
    bx       = (c[27:4] == 24'h12fff1);
    mrs      = (c[27:23] == 5'b00010) && (c[21:16] == 6'b001111) && (c[11:0] == 12'h000);
    msr      = (c[27:23] == 5'b00010) && (c[21:4] == 18'h29f00);
    msr_flag = (c[27:26] == 2'b00) && (c[24:23] == 2'b10) && (c[21:12] == 10'h28f) &&
               (c[25] || (c[11:4] == 8'h00));
    mul      = (c[27:22] == 6'b000000) && (c[7:4] == 4'b1001);
    mull     = (c[27:23] == 5'b00001) && (c[7:4] == 4'b1001);
    swp      = (c[27:23] == 5'b00010) && (c[21:20] == 2'b00) && (c[11:4] == 8'h09);
    hw_ok    = (c[27:25] == 3'b000) && (c[22] || (c[11:8] == 4'h0));
    ldrh     = hw_ok && (c[7:4] == 4'b1011);
    ldrsb    = hw_ok && (c[7:4] == 4'b1101);
    ldrsh    = hw_ok && (c[7:4] == 4'b1111);
    cls = 5'd0;
    case (c[27:26])
      2'b00: begin
        // Overlapping encodings in this quadrant; first match wins, data processing is the fallback.
        if (bx)            cls = 5'd1;
        else if (mrs)      cls = 5'd4;
        else if (msr)      cls = 5'd5;
        else if (msr_flag) cls = 5'd6;
        else if (mul)      cls = 5'd7;
        else if (mull)     cls = 5'd8;
        else if (swp)      cls = 5'd14;
        else if (ldrh)     cls = 5'd10;
        else if (ldrsb)    cls = 5'd11;
        else if (ldrsh)    cls = 5'd12;
        else               cls = 5'd0;
      end
      2'b01:   cls = (c[25] && c[4]) ? 5'd19 : 5'd9;
      2'b10:   cls = !c[25] ? 5'd13 : (c[24] ? 5'd3 : 5'd2);
      default: begin
        if (!c[25])      cls = 5'd17;
        else if (c[24])  cls = 5'd15;
        else if (c[4])   cls = 5'd18;
        else             cls = 5'd16;
      end
    endcase
    return cls;
  endfunction

  function automatic logic [ADDR_W-1:0] branch_target(input logic [ADDR_W-1:0] pc,
                                                     input logic [23:0] imm);
    logic signed [31:0] off;
    off = {{6{imm[23]}}, imm, 2'b00};
    return pc + ADDR_W'(8) + off[ADDR_W-1:0];
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              rst_n_q;
  logic [4:0]        class_q [DEPTH];
  logic [31:0]       code_q  [DEPTH];
  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [ADDR_W-1:0] tgt_q   [DEPTH];
  logic              push, pop;

  assign bus.in_ready  = (count_q != CNT_W'(DEPTH)) && rst_n_q;
  assign bus.out_valid = (count_q != '0);
  assign push = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = ptr_next(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_next(rd_ptr_q);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  // Decode happens on the write side so the head entry drives the outputs straight from registers.
  always_ff @(posedge clk) begin
    rst_n_q <= rst_n;
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        class_q[i] <= '0;
        code_q[i]  <= '0;
        pc_q[i]    <= '0;
        tgt_q[i]   <= '0;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) begin
        class_q[wr_ptr_q] <= decode_class(bus.in_code);
        code_q[wr_ptr_q]  <= bus.in_code;
        pc_q[wr_ptr_q]    <= bus.in_pc;
        tgt_q[wr_ptr_q]   <= branch_target(bus.in_pc, bus.in_code[23:0]);
      end
    end
  end

  assign bus.out_class    = class_q[rd_ptr_q];
  assign bus.out_code     = code_q[rd_ptr_q];
  assign bus.out_cond     = code_q[rd_ptr_q][31:28];
  assign bus.out_rn       = code_q[rd_ptr_q][19:16];
  assign bus.out_rd       = code_q[rd_ptr_q][15:12];
  assign bus.out_rs       = code_q[rd_ptr_q][11:8];
  assign bus.out_rm       = code_q[rd_ptr_q][3:0];
  assign bus.out_pc       = pc_q[rd_ptr_q];
  assign bus.out_b_target = tgt_q[rd_ptr_q];

`ifdef DECODER_STAT_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  logic [STAT_W-1:0] stat_insn_q, stat_stall_q;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_insn_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      if (push) stat_insn_q <= sat_inc(stat_insn_q);
      if (bus.out_valid && !bus.out_ready) stat_stall_q <= sat_inc(stat_stall_q);
    end
  end

  assign bus.stat_insn  = stat_insn_q;
  assign bus.stat_stall = stat_stall_q;
`else
  assign bus.stat_insn  = {STAT_W{1'b0}};
  assign bus.stat_stall = {STAT_W{1'b0}};
`endif
endmodule
